bundle_fetch_queue: RTL

//   Parametrised FIFO of instruction bundles between main_memory fetch and the
//   per-lane decode stages (IXU/LSU/BRU). Generalises direct fetch->decode wiring
//   to NUM_LANES lanes and DEPTH entries. Decouples fetch from hazard stalls and

---
 rtl/bundle_fetch_queue_if.sv | 45 ++++
 rtl/bundle_fetch_queue.sv | 93 +++++++++
 2 files changed

// File: rtl/bundle_fetch_queue_if.sv
// ---------------------------------------------------------------------------
// bundle_fetch_queue_if
//   Handshake bundle between instruction fetch, the bundle fetch queue and the
//   per-lane decode stages.
//   master : fetch/decode side. It drives push_*, pop_ready and flush, and it
//            observes push_ready, pop_*, count and overflow_err.
//   slave  : the queue itself.
//   Signals
//     push_valid / push_ready / push_bundle / push_pc : fetch -> queue
//     pop_valid  / pop_ready  / pop_bundle  / pop_pc  : queue -> decode
//     flush        : branch squash, discards every entry
//     count        : current occupancy, 0..DEPTH
//     overflow_err : sticky, set by a push offered while the queue refuses it
// ---------------------------------------------------------------------------
interface bundle_fetch_queue_if #(
  parameter int NUM_LANES = 4,
  parameter int INST_W    = 32,
  parameter int PC_W      = 32,
  parameter int DEPTH     = 4
);
  localparam int BUNDLE_W = NUM_LANES * INST_W;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic                push_valid;
  logic                push_ready;
  logic [BUNDLE_W-1:0] push_bundle;
  logic [PC_W-1:0]     push_pc;
  logic                pop_ready;
  logic                pop_valid;
  logic [BUNDLE_W-1:0] pop_bundle;
  logic [PC_W-1:0]     pop_pc;
  logic                flush;
  logic [CNT_W-1:0]    count;
  logic                overflow_err;

  modport master (
    output push_valid, push_bundle, push_pc, pop_ready, flush,
    input  push_ready, pop_valid, pop_bundle, pop_pc, count, overflow_err
  );

  modport slave (
    input  push_valid, push_bundle, push_pc, pop_ready, flush,
    output push_ready, pop_valid, pop_bundle, pop_pc, count, overflow_err
  );
endinterface

// File: rtl/bundle_fetch_queue.sv
// ---------------------------------------------------------------------------
// bundle_fetch_queue
//   A first-word-fall-through FIFO of NUM_LANES-wide instruction bundles. It
//   sits between fetch and the per-lane decode stages. A push appears on pop_*
//   in the cycle after the push, and a flush (branch squash) empties the queue
//   in one edge. When the queue is empty, the output shows NOP_INST on every
//   lane and a PC of 0, so decode can consume it unconditionally.
//   Ports
//     clk : rising-edge clock
//     rst : asynchronous reset, active-high
//     q   : bundle_fetch_queue_if.slave (push/pop handshakes, flush, count,
//           overflow_err)
// ---------------------------------------------------------------------------
module bundle_fetch_queue #(
  parameter int              NUM_LANES = 4,
  parameter int              INST_W    = 32,
  parameter int              PC_W      = 32,
  parameter int              DEPTH     = 4,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h00000013)
) (
  input logic                 clk,
  input logic                 rst,
  bundle_fetch_queue_if.slave q
);
  localparam int BUNDLE_W = NUM_LANES * INST_W;
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic [BUNDLE_W-1:0] mem_bundle [DEPTH];
  logic [PC_W-1:0]     mem_pc     [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CNT_W-1:0]    count_q;
  logic                overflow_q;

  logic push_fire;
  logic pop_fire;

  // push_ready depends only on registered occupancy and flush. Because of
  // this, a pop in the same cycle cannot free a slot for a push when the
  // queue is full.
  assign q.push_ready = (count_q < CNT_W'(DEPTH)) && !q.flush;
  assign q.pop_valid  = (count_q != '0);

  assign push_fire = q.push_valid && q.push_ready;
  // A flush takes priority, so a pop offered during a flush is not counted.
  assign pop_fire  = q.pop_valid && q.pop_ready && !q.flush;

  // Head mux over registered state only; there is no bypass from push_* to pop_*.
  assign q.pop_bundle = q.pop_valid ? mem_bundle[rd_ptr] : {NUM_LANES{NOP_INST}};
  assign q.pop_pc     = q.pop_valid ? mem_pc[rd_ptr]     : '0;
  assign q.count        = count_q;
  assign q.overflow_err = overflow_q;

  // NOTE: storage carries no reset. Emptiness is tracked by count_q, so stale
  //       entries are never shown, and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_bundle[wr_ptr] <= q.push_bundle;
      mem_pc[wr_ptr]     <= q.push_pc;
    end
  end

  // NOTE: state registers use non-blocking assignments, so every process
  //       samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (q.push_valid && !q.push_ready && !q.flush) begin
        overflow_q <= 1'b1;
      end

      if (q.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        // DEPTH is a power of two, so the pointers wrap by natural overflow.
        if (push_fire) wr_ptr <= wr_ptr + AW'(1);
        if (pop_fire)  rd_ptr <= rd_ptr + AW'(1);
        case ({push_fire, pop_fire})
          2'b10:   count_q <= count_q + CNT_W'(1);
          2'b01:   count_q <= count_q - CNT_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end
endmodule
